calc_key_player: RTL and testbench
==================================

# calc_key_player

Hardware key-sequence generator that drives the calculator top's keypad-side inputs. It accepts one operation command (two decimal digits plus add/subtract) through a valid/ready handshake. It then replays the physical key protocol the calculator expects: a START clear pulse, an active-low one-hot press on A, then on B, and an EQUAL pulse, with configurable press, gap, settle and hold times. It is the initiator end of the calculator keypad interface and replaces hand-written stimulus for board self-test and regression.

## Interface
- CLR_CYC, 1: cycles START is held low to clear the calculator (≥1)
- PRESS_CYC, 1: cycles each key (A, B, EQUAL) is held asserted (≥1)
- GAP_CYC, 1: released cycles after START rises and after the A press (≥1)
- SETTLE_CYC, 3: released cycles between the B release and EQUAL (≥1)
- HOLD_CYC, 3: cycles after EQUAL before completion (≥1)
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, will accept
- cmd_a  in  4  first operand digit, 0..9
- cmd_b  in  4  second operand digit, 0..9
- cmd_sub  in  1  1 = subtract, 0 = add
- A  out  10  active-low one-hot key bus, operand A (idle 10'h3FF)
- B  out  10  active-low one-hot key bus, operand B (idle 10'h3FF)
- START  out  1  calculator enable; low = clear
- EQUAL  out  1  active-high equal key
- Addn_Sub  out  1  operation select, held between commands
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence complete
- err  out  1  one-cycle pulse, command rejected (digit >9)
- result  in  5  calculator result; present only with RESULT_CHECK_EN
- mismatch  out  1  one-cycle pulse with done; present only with RESULT_CHECK_EN

## Operation
- All outputs are registered. Reset values: A = B = 10'h3FF, START = 1, EQUAL = 0, Addn_Sub = 0, busy = 0, done = 0, err = 0, mismatch = 0, cmd_ready = 1. State is IDLE.
- Accept occurs on a rising edge where cmd_valid && cmd_ready. On accept, cmd_a, cmd_b and cmd_sub are latched, and Addn_Sub takes cmd_sub on the same edge.
- Digit encoding: key bus = ~(10'b1 << d). For example, 0 → 10'b1111111110 and 8 → 10'b1011111111.
- Invalid command (cmd_a >9 or cmd_b >9): err pulses for 1 cycle on the accept edge's next cycle. No key activity occurs and the block returns to IDLE (cmd_ready = 1 in the same cycle as err). Addn_Sub keeps its previous value.
- FSM: IDLE → CLEAR (START = 0, CLR_CYC) → ARM (START = 1, GAP_CYC) → PRESS_A (A one-hot, PRESS_CYC) → GAP_A (GAP_CYC) → PRESS_B (B one-hot, PRESS_CYC) → SETTLE (SETTLE_CYC) → EQ (EQUAL = 1, PRESS_CYC) → HOLD (HOLD_CYC) → DONE (1 cycle, done = 1) → IDLE.
- busy = 1 and cmd_ready = 0 in every state except IDLE. START stays 1 outside CLEAR.
- A and B never assert together. EQUAL never overlaps a key press.
- One 8-bit down-counter is shared across states and reloaded on each state entry.
- RST in any state forces the reset values on the next edge and aborts the sequence without a done pulse.

## Timing
- Accept edge = E. With defaults:
  - START low at E+1
  - A pressed at E+3
  - B pressed at E+5
  - EQUAL at E+9
  - done at E+13, with cmd_ready = 1 in the same cycle
- General latency from accept to done: 1 + CLR_CYC + 2·GAP_CYC + 3·PRESS_CYC + SETTLE_CYC + HOLD_CYC cycles.
- The earliest back-to-back accept is the done cycle, because cmd_ready is high there.
- cmd_valid, cmd_a, cmd_b and cmd_sub are ignored whenever cmd_ready = 0. A command held across reset is accepted on the first edge after RST deasserts.

## Configuration
- RESULT_CHECK_EN defined:
  - Adds the result input and the mismatch output.
  - Expected value: a+b for add; (a−b) mod 32 (5-bit two's complement) for subtract.
  - result is sampled on the last HOLD cycle. mismatch pulses with done if result ≠ expected.
- RESULT_CHECK_EN undefined:
  - Neither port exists and no compare logic is built.
  - All other behaviour is identical.

## Structure
- Package calc_key_pkg holds:
  - the FSM state enum
  - DIGIT_MAX = 9
  - KEY_IDLE = 10'h3FF
  - the expected-result function
- Sub-module key_onehot_enc: 4-bit digit → 10-bit active-low one-hot, plus an invalid flag. It is instantiated twice, for A and B.

## Test plan
- Reset, then add 0+8 → A = 10'b1111111110 at E+3, B = 10'b1011111111 at E+5, EQUAL at E+9, done at E+13, Addn_Sub = 0.
- Subtract 7−4 with RESULT_CHECK_EN and result = 5'd3 → Addn_Sub = 1 from E+1, done with mismatch = 0. Repeat with result = 5'd4 → mismatch = 1.
- Subtract 8−9 with result = 5'b11111 → mismatch = 0. Add 9+9 with result = 5'd18 → mismatch = 0.
- cmd_a = 4'd10 → err pulse at E+1, A/B/START/EQUAL unchanged, cmd_ready = 1.
- Back-to-back commands with cmd_valid held high → second accept on the done edge, second START low exactly one cycle later.
- RST asserted in the SETTLE state → next cycle A = B = 10'h3FF, START = 1, EQUAL = 0, busy = 0, and no done pulse.

Source files
------------

// File: rtl/calc_key_player_pkg.sv
// Shared types and constants for the calculator key-sequence player.
package calc_key_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned KEY_W   = 10;
   localparam int unsigned RES_W   = 5;
   localparam int unsigned CNT_W   = 8;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(9);
   localparam logic [KEY_W-1:0]   KEY_IDLE  = 10'h3FF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_ARM,
      S_PRESS_A,
      S_GAP_A,
      S_PRESS_B,
      S_SETTLE,
      S_EQ,
      S_HOLD,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] a;
      logic [DIGIT_W-1:0] b;
      logic               sub;
   } cmd_t;

   // Result the calculator should show; subtraction wraps as 5-bit two's complement.
   function automatic logic [RES_W-1:0] expected_result(input cmd_t c);
      if (c.sub) return RES_W'(c.a) - RES_W'(c.b);
      return RES_W'(c.a) + RES_W'(c.b);
   endfunction

endpackage

// File: rtl/calc_key_player_if.sv
// Command handshake between a test sequencer and the key player.
interface calc_key_player_if;
   import calc_key_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [DIGIT_W-1:0] cmd_a;
   logic [DIGIT_W-1:0] cmd_b;
   logic               cmd_sub;

   modport master (output cmd_valid, cmd_a, cmd_b, cmd_sub, input cmd_ready);
   modport slave  (input cmd_valid, cmd_a, cmd_b, cmd_sub, output cmd_ready);
endinterface

// File: rtl/key_onehot_enc.sv
// Decimal digit to active-low one-hot key bus, flagging digits above 9.
module key_onehot_enc
   import calc_key_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [KEY_W-1:0]   key_c,
   output logic               invalid_c
);

   always_comb begin
      invalid_c = (digit > DIGIT_MAX);
      key_c     = KEY_IDLE;
      if (!invalid_c) key_c = ~(KEY_W'(1) << digit);
   end

endmodule

// File: rtl/calc_key_player.sv
// Replays START/A/B/EQUAL key protocol for one accepted add/subtract command.
// Optional RESULT_CHECK_EN adds the result input and a mismatch pulse alongside done.
module calc_key_player
   import calc_key_pkg::*;
#(
   parameter int unsigned CLR_CYC    = 1,
   parameter int unsigned PRESS_CYC  = 1,
   parameter int unsigned GAP_CYC    = 1,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned HOLD_CYC   = 3
) (
   input  logic             CLK,
   input  logic             RST,
   calc_key_player_if.slave cmd,
   output logic [KEY_W-1:0] A,
   output logic [KEY_W-1:0] B,
   output logic             START,
   output logic             EQUAL,
   output logic             Addn_Sub,
   output logic             busy,
   output logic             done,
   output logic             err
`ifdef RESULT_CHECK_EN
   ,
   input  logic [RES_W-1:0] result,
   output logic             mismatch
`endif
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [KEY_W-1:0]   key_a;
   logic [KEY_W-1:0]   key_b;
   logic [KEY_W-1:0]   enc_a_c;
   logic [KEY_W-1:0]   enc_b_c;
   logic               inv_a_c;
   logic               inv_b_c;
   logic               last_c;

   key_onehot_enc u_enc_a (.digit(cmd.cmd_a), .key_c(enc_a_c), .invalid_c(inv_a_c));
   key_onehot_enc u_enc_b (.digit(cmd.cmd_b), .key_c(enc_b_c), .invalid_c(inv_b_c));

   assign last_c = (cnt == '0);

`ifdef RESULT_CHECK_EN
   logic [RES_W-1:0] exp_res;
   cmd_t             cmd_c;
   assign cmd_c = '{a: cmd.cmd_a, b: cmd.cmd_b, sub: cmd.cmd_sub};
`endif

   // Single-process sequencer: the shared counter is reloaded with N-1 on every state entry.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         cnt           <= '0;
         key_a         <= KEY_IDLE;
         key_b         <= KEY_IDLE;
         A             <= KEY_IDLE;
         B             <= KEY_IDLE;
         START         <= 1'b1;
         EQUAL         <= 1'b0;
         Addn_Sub      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         cmd.cmd_ready <= 1'b1;
`ifdef RESULT_CHECK_EN
         exp_res       <= '0;
         mismatch      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef RESULT_CHECK_EN
         mismatch <= 1'b0;
`endif
         if (!last_c) cnt <= cnt - CNT_W'(1);

         case (state)
            S_IDLE, S_DONE: begin
               state         <= S_IDLE;
               busy          <= 1'b0;
               cmd.cmd_ready <= 1'b1;
               if (cmd.cmd_valid && cmd.cmd_ready) begin
                  if (inv_a_c || inv_b_c) begin
                     err <= 1'b1;
                  end else begin
                     key_a         <= enc_a_c;
                     key_b         <= enc_b_c;
                     Addn_Sub      <= cmd.cmd_sub;
`ifdef RESULT_CHECK_EN
                     exp_res       <= expected_result(cmd_c);
`endif
                     state         <= S_CLEAR;
                     cnt           <= CNT_W'(CLR_CYC - 1);
                     START         <= 1'b0;
                     busy          <= 1'b1;
                     cmd.cmd_ready <= 1'b0;
                  end
               end
            end
            S_CLEAR: if (last_c) begin
               state <= S_ARM;
               cnt   <= CNT_W'(GAP_CYC - 1);
               START <= 1'b1;
            end
            S_ARM: if (last_c) begin
               state <= S_PRESS_A;
               cnt   <= CNT_W'(PRESS_CYC - 1);
               A     <= key_a;
            end
            S_PRESS_A: if (last_c) begin
               state <= S_GAP_A;
               cnt   <= CNT_W'(GAP_CYC - 1);
               A     <= KEY_IDLE;
            end
            S_GAP_A: if (last_c) begin
               state <= S_PRESS_B;
               cnt   <= CNT_W'(PRESS_CYC - 1);
               B     <= key_b;
            end
            S_PRESS_B: if (last_c) begin
               state <= S_SETTLE;
               cnt   <= CNT_W'(SETTLE_CYC - 1);
               B     <= KEY_IDLE;
            end
            S_SETTLE: if (last_c) begin
               state <= S_EQ;
               cnt   <= CNT_W'(PRESS_CYC - 1);
               EQUAL <= 1'b1;
            end
            S_EQ: if (last_c) begin
               state <= S_HOLD;
               cnt   <= CNT_W'(HOLD_CYC - 1);
               EQUAL <= 1'b0;
            end
            S_HOLD: if (last_c) begin
               state         <= S_DONE;
               done          <= 1'b1;
               cmd.cmd_ready <= 1'b1;
`ifdef RESULT_CHECK_EN
               mismatch      <= (result != exp_res);
`endif
            end
            default: begin
               state         <= S_IDLE;
               busy          <= 1'b0;
               cmd.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_key_player.sv
// Scoreboard bench for calc_key_player: timed key waveform plus done/err events.
module tb_calc_key_player;
   import calc_key_pkg::*;

   localparam int unsigned CLR = 1, PRESS = 1, GAP = 1, SETTLE = 3, HOLD = 3;
   localparam int unsigned LAT = 1 + CLR + 2*GAP + 3*PRESS + SETTLE + HOLD;
   localparam int unsigned T_A  = 1 + CLR + GAP;
   localparam int unsigned T_B  = T_A + PRESS + GAP;
   localparam int unsigned T_EQ = T_B + PRESS + SETTLE;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   calc_key_player_if cmd_if();
   logic [9:0] A, B;
   logic       START, EQUAL, Addn_Sub, busy, done, err;
`ifdef RESULT_CHECK_EN
   logic [4:0] result;
   logic       mismatch;
`endif

   calc_key_player #(
      .CLR_CYC(CLR), .PRESS_CYC(PRESS), .GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .HOLD_CYC(HOLD)
   ) dut (
      .CLK(CLK), .RST(RST), .cmd(cmd_if),
      .A(A), .B(B), .START(START), .EQUAL(EQUAL), .Addn_Sub(Addn_Sub),
      .busy(busy), .done(done), .err(err)
`ifdef RESULT_CHECK_EN
      , .result(result), .mismatch(mismatch)
`endif
   );

   typedef struct {
      bit  is_err;
      time t_exp;
      bit  mm;
   } sb_entry_t;

   sb_entry_t sb[$];
   sb_entry_t ent;
   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [4:0] model_res(input logic [3:0] a, input logic [3:0] b, input logic sub);
      return sub ? (5'(a) - 5'(b)) : (5'(a) + 5'(b));
   endfunction

   task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input logic sub,
                           input logic [4:0] res, input time te);
      sb_entry_t e;
      e.is_err = (a > 4'd9) || (b > 4'd9);
      e.t_exp  = e.is_err ? te + 5 : te + time'((LAT - 1) * 10 + 5);
      e.mm     = (res != model_res(a, b, sub));
      sb.push_back(e);
   endtask

   // Returns at the sample point of cycle E+1 with cmd_valid dropped.
   task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic sub,
                            input logic [4:0] res);
      bit ok = 1'b0;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_a     = a;
      cmd_if.cmd_b     = b;
      cmd_if.cmd_sub   = sub;
`ifdef RESULT_CHECK_EN
      result = res;
`endif
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cmd_if.cmd_ready) ok = 1'b1;
         else @(negedge CLK);
      end
      check_eq("accept_ready", 32'(ok), 1);
      @(posedge CLK);
      push_exp(a, b, sub, res, $time);
      @(negedge CLK);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (cmd_if.cmd_ready && !busy && !done) break;
         @(negedge CLK);
      end
      check_eq("idle_timeout", 32'(cmd_if.cmd_ready && !busy), 1);
   endtask

   // Protocol invariants and event scoreboard, sampled on the falling edge.
   always @(negedge CLK) begin
      if (!RST) begin
         check_eq("ab_overlap", 32'((A != KEY_IDLE) && (B != KEY_IDLE)), 0);
         check_eq("eq_overlap", 32'(EQUAL && ((A != KEY_IDLE) || (B != KEY_IDLE))), 0);
         if (done || err) begin
            if (sb.size() == 0) begin
               check_eq("unexpected_evt", {30'd0, done, err}, 0);
            end else begin
               ent = sb.pop_front();
               check_eq("evt_err", 32'(err), 32'(ent.is_err));
               check_eq("evt_done", 32'(done), 32'(!ent.is_err));
               check_eq("evt_time", 32'($time), 32'(ent.t_exp));
`ifdef RESULT_CHECK_EN
               if (done) check_eq("mismatch", 32'(mismatch), 32'(ent.mm));
`endif
            end
         end
      end
   end

   initial begin
      RST = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_a = '0;
      cmd_if.cmd_b = '0;
      cmd_if.cmd_sub = 1'b0;
`ifdef RESULT_CHECK_EN
      result = '0;
`endif
      repeat (3) @(negedge CLK);
      check_eq("rst_A", 32'(A), 32'h3FF);
      check_eq("rst_B", 32'(B), 32'h3FF);
      check_eq("rst_START", 32'(START), 1);
      check_eq("rst_EQUAL", 32'(EQUAL), 0);
      check_eq("rst_addn_sub", 32'(Addn_Sub), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_ready", 32'(cmd_if.cmd_ready), 1);
`ifdef RESULT_CHECK_EN
      check_eq("rst_mismatch", 32'(mismatch), 0);
`endif
      RST = 1'b0;
      @(negedge CLK);

      // 0 + 8: full cycle-by-cycle waveform
      drive_cmd(4'd0, 4'd8, 1'b0, 5'd8);
      for (int k = 1; k <= int'(LAT) + 1; k++) begin
         check_eq($sformatf("w_START@%0d", k), 32'(START), 32'(!(k <= int'(CLR))));
         check_eq($sformatf("w_A@%0d", k), 32'(A),
                  (k >= int'(T_A) && k < int'(T_A + PRESS)) ? 32'b1111111110 : 32'h3FF);
         check_eq($sformatf("w_B@%0d", k), 32'(B),
                  (k >= int'(T_B) && k < int'(T_B + PRESS)) ? 32'b1011111111 : 32'h3FF);
         check_eq($sformatf("w_EQUAL@%0d", k), 32'(EQUAL),
                  32'(k >= int'(T_EQ) && k < int'(T_EQ + PRESS)));
         check_eq($sformatf("w_done@%0d", k), 32'(done), 32'(k == int'(LAT)));
         check_eq($sformatf("w_busy@%0d", k), 32'(busy), 32'(k <= int'(LAT)));
         check_eq($sformatf("w_ready@%0d", k), 32'(cmd_if.cmd_ready), 32'(k >= int'(LAT)));
         check_eq($sformatf("w_addn_sub@%0d", k), 32'(Addn_Sub), 0);
         @(negedge CLK);
      end

      // invalid digit: err only, no key activity, Addn_Sub untouched
      drive_cmd(4'd10, 4'd3, 1'b1, 5'd0);
      check_eq("err_pulse", 32'(err), 1);
      check_eq("err_A", 32'(A), 32'h3FF);
      check_eq("err_B", 32'(B), 32'h3FF);
      check_eq("err_START", 32'(START), 1);
      check_eq("err_EQUAL", 32'(EQUAL), 0);
      check_eq("err_ready", 32'(cmd_if.cmd_ready), 1);
      check_eq("err_busy", 32'(busy), 0);
      check_eq("err_addn_sub", 32'(Addn_Sub), 0);
      @(negedge CLK);
      check_eq("err_one_cycle", 32'(err), 0);

      drive_cmd(4'd7, 4'd4, 1'b1, 5'd3);
      check_eq("sub_addn_sub", 32'(Addn_Sub), 1);
      check_eq("sub_START", 32'(START), 0);
      wait_idle();
      drive_cmd(4'd7, 4'd4, 1'b1, 5'd4);
      wait_idle();
      drive_cmd(4'd8, 4'd9, 1'b1, 5'b11111);
      wait_idle();
      drive_cmd(4'd9, 4'd9, 1'b0, 5'd18);
      check_eq("add_addn_sub", 32'(Addn_Sub), 0);
      wait_idle();

      // back-to-back with cmd_valid held: second accept on the done edge
      check_eq("b2b_ready", 32'(cmd_if.cmd_ready), 1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_a = 4'd1;
      cmd_if.cmd_b = 4'd2;
      cmd_if.cmd_sub = 1'b0;
`ifdef RESULT_CHECK_EN
      result = 5'd3;
`endif
      @(posedge CLK);
      push_exp(4'd1, 4'd2, 1'b0, 5'd3, $time);
      @(negedge CLK);
      cmd_if.cmd_a = 4'd5;
      cmd_if.cmd_b = 4'd2;
      cmd_if.cmd_sub = 1'b1;
      repeat (LAT - 1) @(negedge CLK);
      check_eq("b2b_done", 32'(done), 1);
      check_eq("b2b_done_ready", 32'(cmd_if.cmd_ready), 1);
      @(posedge CLK);
      push_exp(4'd5, 4'd2, 1'b1, 5'd3, $time);
      @(negedge CLK);
      cmd_if.cmd_valid = 1'b0;
      check_eq("b2b_START", 32'(START), 0);
      check_eq("b2b_addn_sub", 32'(Addn_Sub), 1);
      wait_idle();

      // reset during SETTLE aborts without done
      drive_cmd(4'd2, 4'd5, 1'b0, 5'd7);
      repeat (T_B + PRESS - 1) @(negedge CLK);
      RST = 1'b1;
      sb.delete();
      @(negedge CLK);
      check_eq("abort_A", 32'(A), 32'h3FF);
      check_eq("abort_B", 32'(B), 32'h3FF);
      check_eq("abort_START", 32'(START), 1);
      check_eq("abort_EQUAL", 32'(EQUAL), 0);
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_ready", 32'(cmd_if.cmd_ready), 1);
      RST = 1'b0;
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         @(negedge CLK);
         check_eq("abort_no_done", 32'(done), 0);
      end

      check_eq("sb_empty", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
